weight_pingpong_bram: RTL and testbench

- Double-buffered (ping-pong) weight store for the adder-tree NPU datapath.
- The loader fills one bank while the PE array reads the other.
- Banks hand over by explicit last-write and release handshakes.
- Adds per-lane write enables, address range checking and a fixed 2-cycle registered read pipeline.

---
 rtl/weight_pingpong_bram.sv | 182 ++++++++++++++++++
 tb/tb_weight_pingpong_bram.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_pingpong_bram.sv
// -----------------------------------------------------------------------------
// weight_pingpong_bram
//
// Double-buffered (ping-pong) weight store for the adder-tree NPU datapath.
// The loader fills one bank while the PE array reads the other. Banks are
// handed over by an explicit last-write (loader) and release (reader)
// handshake. Writes have per-lane enables, both ports check the address
// range, and reads go through a fixed 2-cycle registered pipeline.
//
// Ports:
//   clk        rising-edge clock for all logic
//   rst_n      synchronous active-low reset
//   w_en       write strobe
//   w_ready    fill bank is writable (fill bank not full)
//   w_addr     word address within the fill bank
//   w_data     write data word
//   w_lane_en  per-lane write enable, lane i = bits [i*LANE_WIDTH +: LANE_WIDTH]
//   w_last     with an accepted write, marks the fill bank complete
//   r_en       read request
//   r_ready    read bank is loaded
//   r_addr     read word address
//   r_release  reader done with the read bank; frees it
//   r_valid    r_data valid this cycle
//   r_data     read data (holds when r_valid=0)
//   wr_bank    current fill bank index
//   rd_bank    current read bank index
//   bank_full  per-bank loaded flags
//   addr_err   sticky out-of-range access flag
//
// DEPTH must satisfy 2^ADDR_WIDTH >= DEPTH.
// -----------------------------------------------------------------------------
module weight_pingpong_bram #(
  parameter int LANES      = 48,
  parameter int LANE_WIDTH = 8,
  parameter int DATA_WIDTH = LANES * LANE_WIDTH,
  parameter int DEPTH      = 10,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_en,
  output logic                  w_ready,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [LANES-1:0]      w_lane_en,
  input  logic                  w_last,
  input  logic                  r_en,
  output logic                  r_ready,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  input  logic                  r_release,
  output logic                  r_valid,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  wr_bank,
  output logic                  rd_bank,
  output logic [1:0]            bank_full,
  output logic                  addr_err
);

  // Extended-width bound so DEPTH == 2^ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0] DEPTH_BOUND = (ADDR_WIDTH + 1)'(DEPTH);

  // Storage: two banks, no reset, every access registered (block RAM).
  logic [DATA_WIDTH-1:0] mem [0:1][0:DEPTH-1];

  // Control state.
  logic [1:0]            r_full;
  logic                  r_wr_bank;
  logic                  r_rd_bank;
  logic                  r_addr_err;

  // Read pipeline stage 1.
  logic                  r_s1_valid;
  logic                  r_s1_oor;
  logic                  r_s1_bank;
  logic [ADDR_WIDTH-1:0] r_s1_addr;

  // Read pipeline stage 2 (output registers).
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;

  // Handshake decode, derived from registered state only.
  logic w_wr_ready;
  logic w_rd_ready;
  logic w_wr_accept;
  logic w_rd_accept;
  logic w_rel_accept;
  logic w_last_accept;
  logic w_waddr_ok;
  logic w_raddr_ok;

  assign w_wr_ready    = ~r_full[r_wr_bank];
  assign w_rd_ready    = r_full[r_rd_bank];
  assign w_wr_accept   = w_en & w_wr_ready;
  assign w_rd_accept   = r_en & w_rd_ready;
  // A release is only meaningful while the read bank is loaded.
  assign w_rel_accept  = r_release & w_rd_ready;
  // w_last completes the bank even when the write itself is out of range.
  assign w_last_accept = w_wr_accept & w_last;
  assign w_waddr_ok    = ({1'b0, w_addr} < DEPTH_BOUND);
  assign w_raddr_ok    = ({1'b0, r_addr} < DEPTH_BOUND);

  // Bank ownership flags, bank pointers and the sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_full     <= 2'b00;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      // w_last and release can never target the same bank: one needs it
      // empty, the other full, so both bit updates apply independently.
      if (w_last_accept) begin
        r_full[r_wr_bank] <= 1'b1;
        r_wr_bank         <= ~r_wr_bank;
      end
      if (w_rel_accept) begin
        r_full[r_rd_bank] <= 1'b0;
        r_rd_bank         <= ~r_rd_bank;
      end
      if ((w_wr_accept && !w_waddr_ok) || (w_rd_accept && !w_raddr_ok)) begin
        r_addr_err <= 1'b1;
      end
    end
  end

  // Lane-masked write port into the fill bank; out-of-range data is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && w_wr_accept && w_waddr_ok) begin
      for (int i = 0; i < LANES; i++) begin
        if (w_lane_en[i]) begin
          mem[r_wr_bank][w_addr][i*LANE_WIDTH +: LANE_WIDTH] <=
            w_data[i*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  // Read stage 1: capture address and bank so a later release cannot
  // redirect a read that is already in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_oor   <= 1'b0;
      r_s1_bank  <= 1'b0;
      r_s1_addr  <= {ADDR_WIDTH{1'b0}};
    end else begin
      r_s1_valid <= w_rd_accept;
      if (w_rd_accept) begin
        r_s1_oor  <= ~w_raddr_ok;
        r_s1_bank <= r_rd_bank;
        r_s1_addr <= r_addr;
      end
    end
  end

  // Read stage 2: registered RAM output; out-of-range reads return zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= {DATA_WIDTH{1'b0}};
    end else begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        if (r_s1_oor) begin
          r_out_data <= {DATA_WIDTH{1'b0}};
        end else begin
          r_out_data <= mem[r_s1_bank][r_s1_addr];
        end
      end
    end
  end

  assign w_ready   = w_wr_ready;
  assign r_ready   = w_rd_ready;
  assign r_valid   = r_out_valid;
  assign r_data    = r_out_data;
  assign wr_bank   = r_wr_bank;
  assign rd_bank   = r_rd_bank;
  assign bank_full = r_full;
  assign addr_err  = r_addr_err;

endmodule

// File: tb/tb_weight_pingpong_bram.sv
// -----------------------------------------------------------------------------
// tb_weight_pingpong_bram
//
// Directed testbench for weight_pingpong_bram. Inputs change #1 after the
// rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_weight_pingpong_bram;

  localparam int LANES      = 48;
  localparam int LANE_WIDTH = 8;
  localparam int DATA_WIDTH = LANES * LANE_WIDTH;
  localparam int DEPTH      = 10;
  localparam int ADDR_WIDTH = 4;

  logic                  clk;
  logic                  rst_n;
  logic                  w_en;
  logic                  w_ready;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [LANES-1:0]      w_lane_en;
  logic                  w_last;
  logic                  r_en;
  logic                  r_ready;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_release;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  wr_bank;
  logic                  rd_bank;
  logic [1:0]            bank_full;
  logic                  addr_err;

  int n_tests;
  int n_fail;

  logic [DATA_WIDTH-1:0] all_aa;
  logic [DATA_WIDTH-1:0] all_11;
  logic [DATA_WIDTH-1:0] all_ff;
  logic [DATA_WIDTH-1:0] all_55;
  logic [DATA_WIDTH-1:0] mask_exp;

  weight_pingpong_bram #(
    .LANES(LANES), .LANE_WIDTH(LANE_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .w_en(w_en), .w_ready(w_ready), .w_addr(w_addr), .w_data(w_data),
    .w_lane_en(w_lane_en), .w_last(w_last),
    .r_en(r_en), .r_ready(r_ready), .r_addr(r_addr), .r_release(r_release),
    .r_valid(r_valid), .r_data(r_data),
    .wr_bank(wr_bank), .rd_bank(rd_bank), .bank_full(bank_full),
    .addr_err(addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if the observed value is wrong.
  task automatic chk(input string tag, input logic [DATA_WIDTH-1:0] act,
                     input logic [DATA_WIDTH-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word k of the first bank-0 load: k*0x01010101 in the low 32 bits.
  function automatic logic [DATA_WIDTH-1:0] word_k(input int k);
    logic [DATA_WIDTH-1:0] v;
    v = '0;
    v[31:0] = 32'(k) * 32'h0101_0101;
    return v;
  endfunction

  task automatic idle();
    w_en = 1'b0; w_last = 1'b0; w_lane_en = '1; w_addr = '0; w_data = '0;
    r_en = 1'b0; r_release = 1'b0; r_addr = '0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    all_aa  = {LANES{8'hAA}};
    all_11  = {LANES{8'h11}};
    all_ff  = {LANES{8'hFF}};
    all_55  = {LANES{8'h55}};
    mask_exp = {8'hFF, {(LANES-2){8'h11}}, 8'hFF};

    idle();
    rst_n = 1'b0;
    #1;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_bank_full", bank_full, 2'b00);
    chk("rst_wr_bank", wr_bank, 1'b0);
    chk("rst_rd_bank", rd_bank, 1'b0);
    chk("rst_r_valid", r_valid, 1'b0);
    chk("rst_r_data", r_data, '0);
    chk("rst_addr_err", addr_err, 1'b0);
    chk("rst_w_ready", w_ready, 1'b1);
    chk("rst_r_ready", r_ready, 1'b0);

    // Basic load of bank 0.
    for (int k = 0; k < DEPTH; k++) begin
      w_en = 1'b1; w_addr = 4'(k); w_data = word_k(k); w_last = (k == DEPTH-1);
      tick();
    end
    idle();
    chk("load_bank_full", bank_full, 2'b01);
    chk("load_wr_bank", wr_bank, 1'b1);
    chk("load_r_ready", r_ready, 1'b1);

    // Read latency: valid exactly two cycles after acceptance.
    r_en = 1'b1; r_addr = 4'd3;
    tick();
    r_en = 1'b0;
    chk("lat_t1_r_valid", r_valid, 1'b0);
    tick();
    chk("lat_t2_r_valid", r_valid, 1'b1);
    chk("lat_t2_r_data", r_data, word_k(3));
    tick();
    chk("lat_t3_r_valid", r_valid, 1'b0);
    chk("lat_t3_hold", r_data, word_k(3));

    // Stream bank-0 reads while filling bank 1 with 0xAA.
    for (int k = 0; k < DEPTH; k++) begin
      w_en = 1'b1; w_addr = 4'(k); w_data = all_aa; w_last = (k == DEPTH-1);
      r_en = 1'b1; r_addr = 4'(k);
      tick();
      if (k >= 1) begin
        chk($sformatf("stream_valid_%0d", k-1), r_valid, 1'b1);
        chk($sformatf("stream_data_%0d", k-1), r_data, word_k(k-1));
      end
    end
    idle();
    tick();
    chk("stream_data_9", r_data, word_k(9));
    chk("both_bank_full", bank_full, 2'b11);
    chk("both_w_ready", w_ready, 1'b0);
    chk("both_wr_bank", wr_bank, 1'b0);

    // Write attempt while both banks are full: no effect at all.
    w_en = 1'b1; w_addr = 4'd0; w_data = all_55; w_last = 1'b1;
    tick();
    idle();
    chk("blocked_bank_full", bank_full, 2'b11);
    chk("blocked_wr_bank", wr_bank, 1'b0);

    // Release bank 0.
    r_release = 1'b1;
    tick();
    idle();
    chk("rel_rd_bank", rd_bank, 1'b1);
    chk("rel_bank_full", bank_full, 2'b10);

    r_en = 1'b1; r_addr = 4'd0;
    tick();
    idle();
    tick();
    chk("bank1_w0_valid", r_valid, 1'b1);
    chk("bank1_w0_data", r_data, all_aa);

    // Lane mask on bank 0 word 2.
    w_en = 1'b1; w_addr = 4'd2; w_data = all_11;
    tick();
    w_data = all_ff; w_lane_en = '0; w_lane_en[0] = 1'b1; w_lane_en[LANES-1] = 1'b1;
    w_last = 1'b1;
    tick();
    idle();
    chk("mask_bank_full", bank_full, 2'b11);
    r_release = 1'b1;
    tick();
    idle();
    chk("mask_rd_bank", rd_bank, 1'b0);
    r_en = 1'b1; r_addr = 4'd2;
    tick();
    r_addr = 4'd0;
    tick();
    r_en = 1'b0;
    chk("mask_data", r_data, mask_exp);
    tick();
    chk("blocked_mem_unchanged", r_data, word_k(0));
    chk("no_addr_err_yet", addr_err, 1'b0);

    // Out-of-range write with w_last into bank 1.
    w_en = 1'b1; w_addr = 4'd12; w_data = all_55; w_last = 1'b1;
    tick();
    idle();
    chk("oor_w_addr_err", addr_err, 1'b1);
    chk("oor_w_bank_full", bank_full, 2'b11);
    chk("oor_w_wr_bank", wr_bank, 1'b0);

    // Out-of-range read of bank 0.
    r_en = 1'b1; r_addr = 4'd15;
    tick();
    idle();
    tick();
    chk("oor_r_valid", r_valid, 1'b1);
    chk("oor_r_data", r_data, '0);

    // Read together with release: read uses the old bank.
    r_en = 1'b1; r_addr = 4'd5; r_release = 1'b1;
    tick();
    idle();
    chk("same_rd_bank_t1", rd_bank, 1'b1);
    chk("same_bank_full", bank_full, 2'b10);
    tick();
    chk("same_r_valid", r_valid, 1'b1);
    chk("same_r_data", r_data, word_k(5));
    chk("same_rd_bank_t2", rd_bank, 1'b1);

    // Reset one cycle after an accepted read.
    r_en = 1'b1; r_addr = 4'd0;
    tick();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_valid_1", r_valid, 1'b0);
    tick();
    chk("mid_rst_valid_2", r_valid, 1'b0);
    tick();
    chk("mid_rst_valid_3", r_valid, 1'b0);
    chk("mid_rst_bank_full", bank_full, 2'b00);
    chk("mid_rst_wr_bank", wr_bank, 1'b0);
    chk("mid_rst_rd_bank", rd_bank, 1'b0);
    chk("mid_rst_addr_err", addr_err, 1'b0);
    chk("mid_rst_r_data", r_data, '0);
    chk("mid_rst_w_ready", w_ready, 1'b1);
    chk("mid_rst_r_ready", r_ready, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
